// File: rtl/memory_pkg.sv
// memory_pkg: default geometry shared by the memory blocks, plus an
// address-width helper that stays valid for any DEPTH >= 1.
package memory_pkg;

   localparam int MEM_WIDTH = 8;
   localparam int MEM_DEPTH = 256;

   // Address bits needed to index DEPTH words; never less than one bit.
   function automatic int f_AddrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/RAM_2Port_1Clock.sv
// RAM_2Port_1Clock: dual-port block RAM on a single clock.
// Both ports can write; Port B has a registered read data output.
module RAM_2Port_1Clock
   import memory_pkg::*;
#(
   parameter int WIDTH = MEM_WIDTH,
   parameter int DEPTH = MEM_DEPTH,
   localparam int ADDR_W = f_AddrWidth(DEPTH)
)(
   input  logic              i_Clk,
   input  logic [WIDTH-1:0]  i_PortA_Data,
   input  logic [ADDR_W-1:0] i_PortA_Addr,
   input  logic              i_PortA_WE,
   input  logic [WIDTH-1:0]  i_PortB_Data,
   input  logic [ADDR_W-1:0] i_PortB_Addr,
   input  logic              i_PortB_WE,
   output logic [WIDTH-1:0]  o_PortB_Data
);

   logic [WIDTH-1:0] r_Mem [DEPTH];

   // Storage writes from either port and registered Port B read (old data on collision).
   always_ff @(posedge i_Clk) begin
      if (i_PortA_WE) begin
         r_Mem[i_PortA_Addr] <= i_PortA_Data;
      end
      if (i_PortB_WE) begin
         r_Mem[i_PortB_Addr] <= i_PortB_Data;
      end
      o_PortB_Data <= r_Mem[i_PortB_Addr];
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock stream FIFO on top of RAM_2Port_1Clock.
// Port A is the write side, Port B the read side (registered read, so read
// data arrives one cycle after an accepted read).
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags; without it those outputs are tied low.
module sync_fifo
   import memory_pkg::*;
#(
   parameter int WIDTH    = MEM_WIDTH,
   parameter int DEPTH    = MEM_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   localparam int PTR_W   = f_AddrWidth(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
)(
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_Wr_DV,
   input  logic [WIDTH-1:0] i_Wr_Data,
   input  logic             i_Rd_En,
   output logic             o_Rd_DV,
   output logic [WIDTH-1:0] o_Rd_Data,
   output logic [CNT_W-1:0] o_Count,
   output logic             o_Full,
   output logic             o_Empty,
   output logic             o_AF,
   output logic             o_AE,
   output logic             o_Overflow,
   output logic             o_Underflow
);

   logic [PTR_W-1:0] r_WrPtr;
   logic [PTR_W-1:0] r_RdPtr;
   logic [CNT_W-1:0] r_Count;
   logic [CNT_W-1:0] w_CountNext;
   logic             r_Full;
   logic             r_Empty;
   logic             r_AF;
   logic             r_AE;
   logic             r_Rd_DV;
   logic             w_WrOk;
   logic             w_RdOk;

   // Pointers wrap by explicit compare so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] f_NextPtr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

   // Acceptance uses the registered flags: a full write or empty read is dropped
   // regardless of what the other side does in the same cycle.
   assign w_WrOk = i_Wr_DV & ~r_Full;
   assign w_RdOk = i_Rd_En & ~r_Empty;

   // Next occupancy; simultaneous accepted write and read cancel out.
   always_comb begin
      w_CountNext = r_Count;
      if (w_WrOk && !w_RdOk) begin
         w_CountNext = r_Count + CNT_W'(1);
      end else if (!w_WrOk && w_RdOk) begin
         w_CountNext = r_Count - CNT_W'(1);
      end
   end

   // Pointer, count, read-valid and flag registers; flags follow the next count
   // so they always agree with o_Count in the same cycle.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_WrPtr <= '0;
         r_RdPtr <= '0;
         r_Count <= '0;
         r_Full  <= 1'b0;
         r_Empty <= 1'b1;
         r_AF    <= (AF_LEVEL == 0);
         r_AE    <= 1'b1;
         r_Rd_DV <= 1'b0;
      end else begin
         if (w_WrOk) begin
            r_WrPtr <= f_NextPtr(r_WrPtr);
         end
         if (w_RdOk) begin
            r_RdPtr <= f_NextPtr(r_RdPtr);
         end
         r_Count <= w_CountNext;
         r_Full  <= (w_CountNext == CNT_W'(DEPTH));
         r_Empty <= (w_CountNext == '0);
         r_AF    <= (int'(w_CountNext) >= AF_LEVEL);
         r_AE    <= (int'(w_CountNext) <= AE_LEVEL);
         r_Rd_DV <= w_RdOk;
      end
   end

   // Storage: Port A write-only at the write pointer, Port B read-only with its
   // address parked on the read pointer.
   RAM_2Port_1Clock #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_Ram (
      .i_Clk        (i_Clk),
      .i_PortA_Data (i_Wr_Data),
      .i_PortA_Addr (r_WrPtr),
      .i_PortA_WE   (w_WrOk),
      .i_PortB_Data ('0),
      .i_PortB_Addr (r_RdPtr),
      .i_PortB_WE   (1'b0),
      .o_PortB_Data (o_Rd_Data)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic r_Overflow;
   logic r_Underflow;

   // Sticky error flags: set on any rejected request, cleared only by reset.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Overflow  <= 1'b0;
         r_Underflow <= 1'b0;
      end else begin
         if (i_Wr_DV && r_Full) begin
            r_Overflow <= 1'b1;
         end
         if (i_Rd_En && r_Empty) begin
            r_Underflow <= 1'b1;
         end
      end
   end

   assign o_Overflow  = r_Overflow;
   assign o_Underflow = r_Underflow;
`else
   assign o_Overflow  = 1'b0;
   assign o_Underflow = 1'b0;
`endif

   assign o_Rd_DV = r_Rd_DV;
   assign o_Count = r_Count;
   assign o_Full  = r_Full;
   assign o_Empty = r_Empty;
   assign o_AF    = r_AF;
   assign o_AE    = r_AE;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed + randomized test of sync_fifo (DEPTH = 4) against a
// queue-based reference model; one compare process checks every cycle.
module tb_sync_fifo;

   localparam int W     = 8;
   localparam int D     = 4;
   localparam int AF_L  = D - 1;
   localparam int AE_L  = 1;
   localparam int CNT_W = $clog2(D + 1);

   logic             r_Clk = 1'b0;
   logic             r_Rst_L;
   logic             r_Wr_DV;
   logic [W-1:0]     r_Wr_Data;
   logic             r_Rd_En;
   logic             w_Rd_DV;
   logic [W-1:0]     w_Rd_Data;
   logic [CNT_W-1:0] w_Count;
   logic             w_Full;
   logic             w_Empty;
   logic             w_AF;
   logic             w_AE;
   logic             w_Overflow;
   logic             w_Underflow;

   always #5 r_Clk = ~r_Clk;

   sync_fifo #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .i_Clk       (r_Clk),
      .i_Rst_L     (r_Rst_L),
      .i_Wr_DV     (r_Wr_DV),
      .i_Wr_Data   (r_Wr_Data),
      .i_Rd_En     (r_Rd_En),
      .o_Rd_DV     (w_Rd_DV),
      .o_Rd_Data   (w_Rd_Data),
      .o_Count     (w_Count),
      .o_Full      (w_Full),
      .o_Empty     (w_Empty),
      .o_AF        (w_AF),
      .o_AE        (w_AE),
      .o_Overflow  (w_Overflow),
      .o_Underflow (w_Underflow)
   );

   int nChecks = 0;
   int nErrors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] mQ[$];
   logic         mDV   = 1'b0;
   logic [W-1:0] mData = '0;
   logic         mOvf  = 1'b0;
   logic         mUnf  = 1'b0;

   // FIFO semantics at the queue level; acceptance uses occupancy before the edge.
   always @(posedge r_Clk or negedge r_Rst_L) begin
      if (!r_Rst_L) begin
         mQ.delete();
         mDV  = 1'b0;
         mOvf = 1'b0;
         mUnf = 1'b0;
      end else begin
         int n;
         bit wrOk, rdOk;
         n    = mQ.size();
         wrOk = r_Wr_DV && (n < D);
         rdOk = r_Rd_En && (n > 0);
         if (r_Wr_DV && n == D) mOvf = 1'b1;
         if (r_Rd_En && n == 0) mUnf = 1'b1;
         mDV = rdOk;
         if (rdOk) mData = mQ.pop_front();
         if (wrOk) mQ.push_back(r_Wr_Data);
      end
   end

   // Per-cycle comparison against the model, on the falling edge.
   always @(negedge r_Clk) begin
      int n;
      n = mQ.size();
      chk("count", 32'(w_Count), 32'(n));
      chk("full",  32'(w_Full),  32'(n == D));
      chk("empty", 32'(w_Empty), 32'(n == 0));
      chk("af",    32'(w_AF),    32'(n >= AF_L));
      chk("ae",    32'(w_AE),    32'(n <= AE_L));
      chk("rd_dv", 32'(w_Rd_DV), 32'(mDV));
      if (mDV) begin
         chk("rd_data", 32'(w_Rd_Data), 32'(mData));
         $display("read data=%02h count=%0d", w_Rd_Data, w_Count);
      end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow",  32'(w_Overflow),  32'(mOvf));
      chk("underflow", 32'(w_Underflow), 32'(mUnf));
`else
      chk("overflow",  32'(w_Overflow),  32'(0));
      chk("underflow", 32'(w_Underflow), 32'(0));
`endif
   end

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
      r_Wr_DV   = w;
      r_Wr_Data = d;
      r_Rd_En   = r;
      @(posedge r_Clk);
      #1;
   endtask

   localparam logic EXP_ERR =
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      1'b1;
`else
      1'b0;
`endif

   initial begin
      r_Rst_L   = 1'b0;
      r_Wr_DV   = 1'b0;
      r_Wr_Data = '0;
      r_Rd_En   = 1'b0;
      repeat (2) @(posedge r_Clk);
      #1;
      chk("rst_count", 32'(w_Count), 0);
      chk("rst_empty", 32'(w_Empty), 1);
      chk("rst_full",  32'(w_Full),  0);
      chk("rst_dv",    32'(w_Rd_DV), 0);
      chk("rst_ae",    32'(w_AE),    1);
      chk("rst_af",    32'(w_AF),    0);
      r_Rst_L = 1'b1;
      cyc(0, 0, 0);

      // Fill 0x01..0x04, then a dropped 5th write.
      for (int i = 1; i <= 4; i++) begin
         cyc(1, W'(i), 0);
         $display("write data=%02h count=%0d", i, w_Count);
         chk("fill_count", 32'(w_Count), 32'(i));
         if (i == 3) chk("af_at_3", 32'(w_AF), 1);
      end
      chk("full_after_4", 32'(w_Full), 1);
      cyc(1, 8'h05, 0);
      chk("drop_count", 32'(w_Count), 4);
      chk("ovf_full_wr", 32'(w_Overflow), 32'(EXP_ERR));

      // Back-to-back drain.
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 0, 1);
         chk("drain_dv",   32'(w_Rd_DV),   1);
         chk("drain_data", 32'(w_Rd_Data), 32'(i));
      end
      chk("empty_after_drain", 32'(w_Empty), 1);
      cyc(0, 0, 1);
      chk("extra_rd_dv", 32'(w_Rd_DV), 0);
      chk("unf_empty_rd", 32'(w_Underflow), 32'(EXP_ERR));

      // Pointer wrap with count held at 2.
      cyc(1, 8'h01, 0);
      cyc(1, 8'h02, 0);
      for (int i = 3; i <= 8; i++) begin
         cyc(1, W'(i), 1);
         chk("wrap_count", 32'(w_Count),   2);
         chk("wrap_data",  32'(w_Rd_Data), 32'(i - 2));
      end
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("wrap_last", 32'(w_Rd_Data), 8);

      // Simultaneous write/read while empty: only the write lands.
      cyc(1, 8'h5A, 1);
      chk("ew_count", 32'(w_Count), 1);
      chk("ew_dv",    32'(w_Rd_DV), 0);
      cyc(0, 0, 1);
      chk("ew_rd_dv",   32'(w_Rd_DV),   1);
      chk("ew_rd_data", 32'(w_Rd_Data), 8'h5A);

      // Mid-stream reset with a read in flight.
      cyc(1, 8'h11, 0);
      cyc(1, 8'h22, 0);
      cyc(1, 8'h33, 0);
      cyc(1, 8'h44, 1);
      chk("pre_rst_dv", 32'(w_Rd_DV), 1);
      r_Wr_DV = 1'b0;
      r_Rd_En = 1'b0;
      r_Rst_L = 1'b0;
      #1;
      chk("mid_rst_count", 32'(w_Count), 0);
      chk("mid_rst_empty", 32'(w_Empty), 1);
      chk("mid_rst_full",  32'(w_Full),  0);
      chk("mid_rst_dv",    32'(w_Rd_DV), 0);
      @(posedge r_Clk);
      #1;
      r_Rst_L = 1'b1;
      cyc(1, 8'hA5, 0);
      cyc(0, 0, 1);
      chk("post_rst_dv",   32'(w_Rd_DV),   1);
      chk("post_rst_data", 32'(w_Rd_Data), 8'hA5);
      chk("post_rst_ovf",  32'(w_Overflow), 0);

      // Randomized traffic with phases biased toward full and toward empty.
      for (int ph = 0; ph < 8; ph++) begin
         int wp, rp;
         wp = (ph % 2 == 0) ? 75 : 25;
         rp = 100 - wp;
         for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 199) == 0) begin
               r_Rst_L = 1'b0;
               #2;
               r_Rst_L = 1'b1;
            end
            cyc(($urandom_range(0, 99) < wp), W'($urandom), ($urandom_range(0, 99) < rp));
         end
      end
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
